// File: rtl/cnn_pkg.sv
// Shared types for the CNN inference sequencer: stage ids, FSM states and
// the one-hot stage decode used for start pulses.
package cnn_pkg;

  localparam int N_STAGES = 4;

  typedef enum logic [1:0] {
    CONV  = 2'd0,
    RELU  = 2'd1,
    POOL  = 2'd2,
    DENSE = 2'd3
  } stage_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    NEXT,
    FINISH,
    FAULT
  } seq_state_t;

  function automatic logic [N_STAGES-1:0] stage_onehot(input stage_t s);
    logic [N_STAGES-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES.
module stage_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && cnt_q != LIMIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // High during the enabled cycle whose count brings the total to the limit.
  assign expired_o = enable_i && (cnt_q >= LAST);

endmodule

// File: rtl/inference_sequencer.sv
// Walks conv -> relu -> maxpool -> dense, one engine at a time, owning the
// shared BRAM mux. A full pass reports cycles = 4*(L+3)+1 for engine latency L.
module inference_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic [N_STAGES-1:0]  stage_start,
  input  logic [N_STAGES-1:0]  stage_done,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_stage,
  output logic [CNT_WIDTH-1:0] cycles
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("inference_sequencer: TIMEOUT_CYCLES must be nonzero");
  end

  seq_state_t           state_q, state_d;
  stage_t               s_q, s_d;
  logic [N_STAGES-1:0]  start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  stage_t               err_stage_q, err_stage_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic                 wd_clear, wd_en, wd_expired;

  stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = LAUNCH;
          s_d     = CONV;
        end
      end
      LAUNCH: begin
        wd_clear = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // A done landing on the expiry cycle still counts as success.
        if (stage_done[s_q])
          state_d = NEXT;
        else if (wd_expired)
          state_d = FAULT;
      end
      NEXT: begin
        if (s_q == DENSE) begin
          state_d = FINISH;
        end else begin
          state_d = LAUNCH;
          s_d     = stage_t'(s_q + 2'd1);
        end
      end
      FINISH:  state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Start is registered off LAUNCH, so it appears one cycle after owner moves.
    start_d     = (state_q == LAUNCH) ? stage_onehot(s_q) : '0;
    busy_d      = (state_d == LAUNCH) || (state_d == WAIT) ||
                  (state_d == NEXT)   || (state_d == FINISH);
    done_d      = (state_d == FINISH);
    error_d     = error_q || (state_d == FAULT);
    err_stage_d = err_stage_q;
    if (state_q == WAIT && state_d == FAULT)
      err_stage_d = s_q;
    cycles_d = cycles_q;
    if (state_q == IDLE && run)
      cycles_d = '0;
    else if (busy_q && cycles_q != '1)
      cycles_d = cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= CONV;
      start_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= CONV;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
      cycles_q    <= cycles_d;
    end
  end

  assign stage_start = start_q;
  assign owner       = s_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_stage   = err_stage_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: a per-stage engine model answers
// start pulses after a programmable latency (0 = never answers).
module tb_inference_sequencer;

  localparam int TO = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, run;
  logic [3:0]    stage_start, stage_done;
  logic [1:0]    owner, err_stage;
  logic          busy, done, error;
  logic [CW-1:0] cycles;

  always #5 clk = ~clk;

  inference_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .owner       (owner),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_stage   (err_stage),
    .cycles      (cycles)
  );

  int n_chk = 0;
  int n_err = 0;

  int         dly [4];
  int         pend_cnt;
  logic [1:0] pend_stage;
  logic [3:0] inj;
  int         cyc = 0;
  int         n_starts, n_dones;
  int         start_log [8];
  int         last_start_cyc [4];
  logic [1:0] owner_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive this cycle's engine done pulses, then observe outputs.
  task automatic tick();
    logic [1:0] idx;
    @(posedge clk);
    #1;
    cyc++;
    stage_done = inj;
    inj        = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) stage_done[pend_stage] = 1'b1;
    end
    if (stage_start != 4'b0000) begin
      idx = 2'd0;
      for (int k = 0; k < 4; k++) if (stage_start[k]) idx = 2'(k);
      chk("start_onehot", 64'($onehot(stage_start)), 64'd1);
      chk("owner_at_start", 64'(owner), 64'(idx));
      if (n_starts < 8) start_log[n_starts] = int'(idx);
      n_starts++;
      last_start_cyc[idx] = cyc;
      pend_stage = idx;
      pend_cnt   = dly[idx];
    end
    if (owner != owner_prev) chk("owner_move_no_start", 64'(stage_start), 64'd0);
    owner_prev = owner;
    if (done) n_dones++;
  endtask

  task automatic clr_stats();
    n_starts = 0;
    n_dones  = 0;
    pend_cnt = 0;
    inj      = '0;
    for (int k = 0; k < 4; k++) last_start_cyc[k] = -1000;
    for (int k = 0; k < 8; k++) start_log[k] = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clr_stats();
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_for_done(input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) tick();
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic wait_for_error(input int budget);
    for (int k = 0; k < budget && error !== 1'b1; k++) tick();
    chk("error_seen", 64'(error), 64'd1);
  endtask

  task automatic expect_order(input int base);
    for (int k = 0; k < 4; k++) chk("start_order", 64'(start_log[base+k]), 64'(k));
  endtask

  task automatic expect_reset_vals(input string tag);
    chk({tag, "_start"},  64'(stage_start), 64'd0);
    chk({tag, "_owner"},  64'(owner),       64'd0);
    chk({tag, "_busy"},   64'(busy),        64'd0);
    chk({tag, "_done"},   64'(done),        64'd0);
    chk({tag, "_error"},  64'(error),       64'd0);
    chk({tag, "_errstg"}, 64'(err_stage),   64'd0);
    chk({tag, "_cycles"}, 64'(cycles),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1; run = 1'b0; stage_done = '0; owner_prev = 2'd0;
    dly = '{5, 5, 5, 5};
    clr_stats();
    repeat (3) tick();
    expect_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk("post_rst_start", 64'(stage_start), 64'd0);

    // Normal pass: each stage is 1 LAUNCH + 6 WAIT + 1 NEXT = 8, plus FINISH.
    pulse_run();
    chk("launch_busy",   64'(busy),   64'd1);
    chk("launch_cycles", 64'(cycles), 64'd0);
    chk("launch_owner",  64'(owner),  64'd0);
    wait_for_done(100);
    chk("fin_busy",   64'(busy),   64'd1);
    chk("fin_cycles", 64'(cycles), 64'd32);
    chk("fin_starts", 64'(n_starts), 64'd4);
    chk("fin_error",  64'(error),  64'd0);
    expect_order(0);
    tick();
    chk("idle_done",   64'(done),   64'd0);
    chk("idle_busy",   64'(busy),   64'd0);
    chk("idle_cycles", 64'(cycles), 64'd33);
    chk("idle_owner",  64'(owner),  64'd3);
    repeat (3) tick();
    chk("hold_cycles", 64'(cycles), 64'd33);
    chk("hold_owner",  64'(owner),  64'd3);
    chk("one_done",    64'(n_dones), 64'd1);

    // Race: relu done lands on the 16th WAIT cycle, i.e. the expiry cycle.
    clr_stats();
    dly = '{5, 15, 5, 5};
    pulse_run();
    wait_for_done(150);
    chk("race_error",  64'(error),    64'd0);
    chk("race_starts", 64'(n_starts), 64'd4);
    expect_order(0);
    tick();
    chk("race_cycles", 64'(cycles), 64'd43);

    // Timeout on pool: error rises 16 cycles after the pool start pulse.
    clr_stats();
    dly = '{5, 5, 0, 5};
    pulse_run();
    wait_for_error(150);
    chk("to_lat",    64'(cyc - last_start_cyc[2]), 64'd16);
    chk("to_stage",  64'(err_stage), 64'd2);
    chk("to_busy",   64'(busy),      64'd0);
    chk("to_starts", 64'(n_starts),  64'd3);
    chk("to_dones",  64'(n_dones),   64'd0);
    run = 1'b1;
    repeat (5) tick();
    chk("fault_hold_err",    64'(error),     64'd1);
    chk("fault_hold_stage",  64'(err_stage), 64'd2);
    chk("fault_hold_busy",   64'(busy),      64'd0);
    chk("fault_hold_starts", 64'(n_starts),  64'd3);
    do_reset();
    expect_reset_vals("fault_rst");

    // One cycle past the race: relu done at the 17th WAIT cycle is too late.
    dly = '{5, 16, 5, 5};
    pulse_run();
    wait_for_error(150);
    chk("to1_lat",    64'(cyc - last_start_cyc[1]), 64'd16);
    chk("to1_stage",  64'(err_stage), 64'd1);
    chk("to1_starts", 64'(n_starts),  64'd2);
    do_reset();

    // Spurious dense done during conv WAIT with run held high throughout.
    dly = '{5, 5, 5, 5};
    run = 1'b1;
    for (int k = 0; k < 20 && n_starts < 1; k++) tick();
    chk("sp_conv_start", 64'(n_starts), 64'd1);
    tick();
    inj = 4'b1000;
    wait_for_done(100);
    chk("sp_starts", 64'(n_starts), 64'd4);
    chk("sp_cycles", 64'(cycles),   64'd32);
    expect_order(0);
    tick();
    chk("sp_idle_busy",   64'(busy),     64'd0);
    chk("sp_idle_starts", 64'(n_starts), 64'd4);
    tick();
    chk("sp_rerun_busy",   64'(busy),   64'd1);
    chk("sp_rerun_cycles", 64'(cycles), 64'd0);
    run = 1'b0;
    wait_for_done(100);
    chk("sp_second_starts", 64'(n_starts), 64'd8);
    expect_order(4);
    repeat (3) tick();
    chk("sp_no_third", 64'(busy), 64'd0);

    // Reset during dense WAIT; dense done arrives just after reset and is ignored.
    clr_stats();
    dly = '{5, 5, 5, 3};
    pulse_run();
    for (int k = 0; k < 100 && n_starts < 4; k++) tick();
    chk("rd_dense_start", 64'(n_starts), 64'd4);
    reset = 1'b1;
    tick();
    expect_reset_vals("rd");
    reset = 1'b0;
    tick();
    chk("rd_no_start", 64'(stage_start), 64'd0);
    repeat (3) tick();
    chk("rd_idle_busy",   64'(busy),     64'd0);
    chk("rd_idle_starts", 64'(n_starts), 64'd4);
    chk("rd_idle_error",  64'(error),    64'd0);
    clr_stats();
    dly = '{5, 5, 5, 5};
    pulse_run();
    wait_for_done(100);
    chk("rd_pass_cycles", 64'(cycles),   64'd32);
    chk("rd_pass_starts", 64'(n_starts), 64'd4);
    chk("rd_pass_error",  64'(error),    64'd0);
    expect_order(0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
